// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer, the 64x13 program memory and the datapath.
// The master side belongs to the sequencer: it drives the memory address and
// the instruction/valid pair, and it receives memory data, ready and zero_flag.
interface fetch_sequencer_if;
    logic [5:0]  pm_addr;
    logic [12:0] pm_ins;
    logic [12:0] ir;
    logic        ex_valid;
    logic        ex_ready;
    logic        zero_flag;

    modport master (
        output pm_addr,
        output ir,
        output ex_valid,
        input  pm_ins,
        input  ex_ready,
        input  zero_flag
    );

    modport slave (
        input  pm_addr,
        input  ir,
        input  ex_valid,
        output pm_ins,
        output ex_ready,
        output zero_flag
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: holds the PC, fetches {opcode, operand} into the
// instruction register, resolves JMP/JZ/HLT itself and hands every other opcode
// to the datapath over a valid/ready handshake.
// Optional feature macro: CALL_STACK_EN adds a 4-entry return stack that serves
// CALL/RET; without it those opcodes are ordinary datapath instructions and
// stack_err is tied low.
module fetch_sequencer (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    fetch_sequencer_if.master bus,
    output logic              halted,
    output logic              stack_err
);
    localparam logic [4:0] OP_JMP = 5'h1C;
    localparam logic [4:0] OP_JZ  = 5'h1D;
    localparam logic [4:0] OP_HLT = 5'h1F;

    typedef enum logic [1:0] {
        S_HALT   = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2,
        S_ISSUE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  pc_q, pc_d;
    logic [12:0] ir_q, ir_d;
    logic [5:0]  target;

    // Jump targets use only the low six operand bits; ir[7:6] are ignored.
    assign target = ir_q[5:0];

`ifdef CALL_STACK_EN
    localparam logic [4:0] OP_CALL     = 5'h1A;
    localparam logic [4:0] OP_RET      = 5'h1B;
    localparam int         STACK_DEPTH = 4;
    localparam int         SP_W        = $clog2(STACK_DEPTH + 1);
    localparam int         IDX_W       = $clog2(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

    logic [SP_W-1:0]  sp_q, sp_d;
    logic             err_q, err_d;
    logic             push;
    logic [IDX_W-1:0] top_idx;
    logic [5:0]       stack_q [STACK_DEPTH];

    // sp points one past the top entry, so the top lives at sp-1.
    assign top_idx   = IDX_W'(sp_q - SP_ONE);
    assign stack_err = err_q;

    // Control registers for the return stack; they survive HALT and run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Return-address storage; the pushed value is the already-incremented PC.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[sp_q[IDX_W-1:0]] <= pc_q;
        end
    end
`else
    assign stack_err = 1'b0;
`endif

    // State, PC and instruction register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_HALT;
            pc_q    <= 6'd0;
            ir_q    <= 13'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state and control-flow resolution.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
`ifdef CALL_STACK_EN
        sp_d    = sp_q;
        err_d   = err_q;
        push    = 1'b0;
`endif
        case (state_q)
            S_HALT: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = bus.pm_ins;
                pc_d    = pc_q + 6'd1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_FETCH;
                case (ir_q[12:8])
                    OP_JMP: pc_d = target;
                    OP_JZ: begin
                        if (bus.zero_flag) begin
                            pc_d = target;
                        end
                    end
                    OP_HLT: state_d = S_HALT;
`ifdef CALL_STACK_EN
                    OP_CALL: begin
                        if (sp_q < SP_FULL) begin
                            push = 1'b1;
                            sp_d = sp_q + SP_ONE;
                            pc_d = target;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_HALT;
                        end
                    end
                    OP_RET: begin
                        if (sp_q != '0) begin
                            pc_d = stack_q[top_idx];
                            sp_d = sp_q - SP_ONE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_HALT;
                        end
                    end
`endif
                    default: state_d = S_ISSUE;
                endcase
            end
            S_ISSUE: begin
                if (bus.ex_ready) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    // ex_valid is decoded from the state so an asynchronous reset drops it at once.
    assign bus.pm_addr  = pc_q;
    assign bus.ir       = ir_q;
    assign bus.ex_valid = (state_q == S_ISSUE);
    assign halted       = (state_q == S_HALT);
endmodule
